// File: rtl/pulse_sync_pkg.sv
// Shared types and limits for the fast-to-slow pulse synchronizer.
package pulse_sync_pkg;
  typedef enum logic {IDLE = 1'b0, WAIT_ACK = 1'b1} src_state_t;
  localparam int SYNC_STAGE_MIN = 2;
endpackage

// File: rtl/sync_ff.sv
// Multi-flop single-bit synchronizer with asynchronous active-low clear.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic clr_n,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) chain <= '0;
    else        chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];
endmodule

// File: rtl/sync_pulse_fast2slow.sv
// Fast-to-slow event crossing: toggle req/ack handshake with a one-deep
// pending buffer and a saturating count of events that could not be held.
module sync_pulse_fast2slow
  import pulse_sync_pkg::*;
#(
  parameter int SYNC_STAGE = 2,
  parameter int CNT_W      = 8
) (
  input  logic             clk_source,
  input  logic             rst_dest,
  input  logic             clk_dest,
  input  logic             sig_pulse_source,
  output logic             busy_source,
  output logic [CNT_W-1:0] drop_count_source,
  output logic             sig_pulse_dest
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic       src_rst_n, dst_rst_n;
  logic       req_tgl, req_nxt, req_sync;
  logic       ack_tgl, ack_sync;
  logic       pending, pend_nxt, drop_inc;
  src_state_t state, state_nxt;

  // Assertion is immediate in both domains; release is re-timed per domain.
  sync_ff #(.STAGES(SYNC_STAGE)) u_src_rst (
    .clk(clk_source), .clr_n(rst_dest), .d(1'b1), .q(src_rst_n));
  sync_ff #(.STAGES(SYNC_STAGE)) u_dst_rst (
    .clk(clk_dest), .clr_n(rst_dest), .d(1'b1), .q(dst_rst_n));
  sync_ff #(.STAGES(SYNC_STAGE)) u_req_sync (
    .clk(clk_dest), .clr_n(dst_rst_n), .d(req_tgl), .q(req_sync));
  sync_ff #(.STAGES(SYNC_STAGE)) u_ack_sync (
    .clk(clk_source), .clr_n(src_rst_n), .d(ack_tgl), .q(ack_sync));

  always_comb begin
    state_nxt = state;
    req_nxt   = req_tgl;
    pend_nxt  = pending;
    drop_inc  = 1'b0;
    case (state)
      IDLE: begin
        if (sig_pulse_source) begin
          req_nxt   = ~req_tgl;
          state_nxt = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (ack_sync != req_tgl) begin
          if (sig_pulse_source) begin
            if (!pending) pend_nxt = 1'b1;
            else          drop_inc = 1'b1;
          end
        end else if (pending) begin
          // Launch the buffered event; a coincident pulse takes its slot.
          req_nxt  = ~req_tgl;
          pend_nxt = sig_pulse_source;
        end else if (sig_pulse_source) begin
          req_nxt = ~req_tgl;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_source or negedge src_rst_n) begin
    if (!src_rst_n) begin
      state             <= IDLE;
      req_tgl           <= 1'b0;
      pending           <= 1'b0;
      busy_source       <= 1'b0;
      drop_count_source <= '0;
    end else begin
      state       <= state_nxt;
      req_tgl     <= req_nxt;
      pending     <= pend_nxt;
      busy_source <= (state_nxt == WAIT_ACK);
      if (drop_inc && drop_count_source != CNT_MAX)
        drop_count_source <= drop_count_source + CNT_W'(1);
    end
  end

  // The edge-detect flop doubles as the ack toggle returned to the source.
  always_ff @(posedge clk_dest or negedge dst_rst_n) begin
    if (!dst_rst_n) begin
      ack_tgl        <= 1'b0;
      sig_pulse_dest <= 1'b0;
    end else begin
      ack_tgl        <= req_sync;
      sig_pulse_dest <= req_sync ^ ack_tgl;
    end
  end
endmodule

// File: doc/sync_pulse_fast2slow.md
# sync_pulse_fast2slow

Transfers single-cycle event pulses from a fast clock domain (clk_source) into a slower, fully asynchronous domain (clk_dest) using a toggle request/acknowledge handshake. It complements the slow-to-fast pulse synchronizer, where plain level sampling suffices, and sits at every fast-to-slow event crossing. Short pulses cannot be missed, and overlapping events are buffered (one deep) or counted as dropped, never silently lost.

## Interface

- SYNC_STAGE, 2, flops per synchronizer chain (req, ack, reset de-assert); legal ≥ 2
- CNT_W, 8, width of the saturating drop counter
- clk_source  in  1  fast source clock
- rst_dest  in  1  reset, asynchronous, active-low; clock clk_source (also resets clk_dest logic)
- clk_dest  in  1  slow destination clock, asynchronous to clk_source
- sig_pulse_source  in  1  event strobe, clk_source domain; each high cycle is one event
- busy_source  out  1  handshake in flight, clk_source domain
- drop_count_source  out  CNT_W  events discarded, saturating, clk_source domain
- sig_pulse_dest  out  1  one-clk_dest-cycle output pulse per delivered event

## Operation

- Reset: rst_dest low asynchronously clears every flop in both domains. De-assertion is re-synchronized separately into each domain through SYNC_STAGE flops. Reset values: busy_source 0, drop_count_source 0, sig_pulse_dest 0, req/ack toggles 0, pending 0, state IDLE.
- Source FSM (clk_source), states IDLE and WAIT_ACK:
  - IDLE & sig_pulse_source: toggle req_tgl, go to WAIT_ACK.
  - WAIT_ACK & ack_sync != req_tgl: stay. A pulse arriving here sets pending if pending=0; otherwise drop_count_source increments, saturating at 2^CNT_W−1.
  - WAIT_ACK & ack_sync == req_tgl (completion cycle):
    - pending=1: toggle req_tgl, clear pending, stay in WAIT_ACK. A pulse in the same cycle becomes the new pending.
    - pending=0 & pulse: toggle req_tgl, stay in WAIT_ACK.
    - Otherwise: go to IDLE.
- busy_source = (state == WAIT_ACK), registered.
- Destination (clk_dest):
  - req_tgl passes through the SYNC_STAGE synchronizer, then one edge-detect flop.
  - sig_pulse_dest = sync_out XOR prev, registered. It is high for exactly one clk_dest cycle per req toggle.
  - The ack toggle is the edge-detect flop value. It returns to the source domain through SYNC_STAGE flops to form ack_sync.
- Delivered events equal accepted events. Total source events = delivered + drop_count_source (while unsaturated).
- No combinational path crosses domains. Only req_tgl and ack cross, each a single registered bit.

## Timing

- Forward latency: req_tgl changes 1 clk_source cycle after the accepting edge. sig_pulse_dest asserts SYNC_STAGE+1 to SYNC_STAGE+2 clk_dest edges later.
- Handshake period: busy_source lasts at most (SYNC_STAGE+2) clk_dest cycles + (SYNC_STAGE+2) clk_source cycles per event.
- Back-to-back pulses into sig_pulse_dest are separated by at least SYNC_STAGE+1 clk_dest cycles.
- Reset asserted mid-handshake: both domains clear immediately. Any in-flight or pending event is lost and is not counted as dropped. No spurious sig_pulse_dest occurs after release, because both toggles restart at 0.
- drop_count_source updates 1 clk_source cycle after the dropped pulse.

## Structure

- Package pulse_sync_pkg:
  - enum src_state_t {IDLE, WAIT_ACK}
  - localparam SYNC_STAGE_MIN = 2
- Sub-module sync_ff (parameter STAGES, async active-low clear), instantiated four times:
  - req chain
  - ack chain
  - source-domain reset de-assert
  - dest-domain reset de-assert
- The top-level module holds the source FSM, pending bit, drop counter and destination edge detector.

## Test plan

- Single event: clk_source 10 ns, clk_dest 37 ns, one 1-cycle pulse.
  - Exactly one sig_pulse_dest, 1 clk_dest cycle wide, within SYNC_STAGE+2 clk_dest edges.
  - busy_source returns to 0; drop_count_source = 0.
- Burst of 2: pulses on consecutive clk_source cycles.
  - Second pulse is pending; two sig_pulse_dest pulses are delivered.
  - drop_count_source = 0.
- Burst of 5: pulses on consecutive clk_source cycles.
  - 2 delivered, drop_count_source = 3.
- Saturation: CNT_W=2, 10 events while busy.
  - drop_count_source holds at 3 and does not wrap.
- Completion collision: pulse driven exactly on the ack-match cycle with pending=1.
  - Pending is launched and the new pulse becomes pending; 3 total delivered, 0 dropped.
- Reset mid-handshake: pull rst_dest low while busy_source=1, release after 3 clk_dest cycles.
  - All outputs read 0 during reset; no sig_pulse_dest after release.
  - A following single event is delivered normally.
